// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the asynchronous FIFO: synchronises the Gray write
// pointer, keeps the read pointers and derives empty, fill level and underflow.
module fifo_rd_ctrl #(
   parameter int ADDR_WIDTH = 4,
   parameter int AE_LEVEL   = 2
) (
   input  logic                  RCLK,
   input  logic                  RRSTn,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH:0]   wpt,
   output logic [ADDR_WIDTH:0]   rpt,
   output logic [ADDR_WIDTH-1:0] raddr,
   output logic                  mem_ren,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   rd_count,
   output logic                  underflow
);

   localparam int            PW     = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // XOR prefix from the MSB down.
   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [PW-1:0] wp1;
   logic [PW-1:0] wp2;
   logic [PW-1:0] rbin;
   logic [PW-1:0] rbin_next;
   logic [PW-1:0] rgray_next;
   logic [PW-1:0] wbin_s;
   logic [PW-1:0] level_next;
   logic          accept;

   // Read accept and next-pointer computation
   assign accept     = rd_en & ~empty;
   assign mem_ren    = accept;
   assign raddr      = rbin[ADDR_WIDTH-1:0];
   assign rbin_next  = rbin + PW'(accept);
   assign rgray_next = bin2gray(rbin_next);

   // Fill level against the synchronised (hence lagging) write pointer
   assign wbin_s     = gray2bin(wp2);
   assign level_next = wbin_s - rbin_next;

   // Synchroniser, pointer and flag registers; rpt comes straight from a flop
   always_ff @(posedge RCLK or negedge RRSTn) begin
      if (!RRSTn) begin
         wp1          <= '0;
         wp2          <= '0;
         rbin         <= '0;
         rpt          <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         rd_count     <= '0;
         underflow    <= 1'b0;
      end else begin
         wp1          <= wpt;
         wp2          <= wp1;
         rbin         <= rbin_next;
         rpt          <= rgray_next;
         empty        <= (rgray_next == wp2);
         rd_count     <= level_next;
         almost_empty <= (level_next <= AE_THR);
         underflow    <= rd_en & empty;
      end
   end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl (ADDR_WIDTH=4, AE_LEVEL=2) with a read-address scoreboard.
module tb_fifo_rd_ctrl;

   logic       RCLK;
   logic       RRSTn;
   logic       rd_en;
   logic [4:0] wpt;
   logic [4:0] rpt;
   logic [3:0] raddr;
   logic       mem_ren;
   logic       empty;
   logic       almost_empty;
   logic [4:0] rd_count;
   logic       underflow;

   int n_pass;
   int n_total;
   logic [3:0] sb[$];

   fifo_rd_ctrl #(.ADDR_WIDTH(4), .AE_LEVEL(2)) dut (
      .RCLK(RCLK),
      .RRSTn(RRSTn),
      .rd_en(rd_en),
      .wpt(wpt),
      .rpt(rpt),
      .raddr(raddr),
      .mem_ren(mem_ren),
      .empty(empty),
      .almost_empty(almost_empty),
      .rd_count(rd_count),
      .underflow(underflow)
   );

   initial RCLK = 1'b0;
   always #5 RCLK = ~RCLK;

   function automatic logic [4:0] g(input int b);
      logic [4:0] v;
      v = b[4:0];
      return v ^ (v >> 1);
   endfunction

   task automatic do_reset();
      RRSTn = 1'b0;
      rd_en = 1'b0;
      wpt   = '0;
      sb.delete();
      @(negedge RCLK);
      @(negedge RCLK);
      RRSTn = 1'b1;
      @(negedge RCLK);
   endtask

   task automatic test_reset();
      @(negedge RCLK);
      RRSTn = 1'b0;
      repeat (4) begin
         wpt   = 5'($urandom);
         rd_en = 1'($urandom);
         @(negedge RCLK);
      end
      rd_en = 1'b1;
      #1;
      n_total++; if (empty !== 1'b1) $display("FAIL rst_empty: got %0b want 1", empty); else n_pass++;
      n_total++; if (almost_empty !== 1'b1) $display("FAIL rst_ae: got %0b want 1", almost_empty); else n_pass++;
      n_total++; if (rpt !== 5'd0) $display("FAIL rst_rpt: got %0h want 0", rpt); else n_pass++;
      n_total++; if (raddr !== 4'd0) $display("FAIL rst_raddr: got %0h want 0", raddr); else n_pass++;
      n_total++; if (rd_count !== 5'd0) $display("FAIL rst_count: got %0d want 0", rd_count); else n_pass++;
      n_total++; if (underflow !== 1'b0) $display("FAIL rst_uf: got %0b want 0", underflow); else n_pass++;
      n_total++; if (mem_ren !== 1'b0) $display("FAIL rst_mren: got %0b want 0", mem_ren); else n_pass++;
      wpt   = '0;
      rd_en = 1'b0;
      @(negedge RCLK);
      RRSTn = 1'b1;
      repeat (3) @(negedge RCLK);
      n_total++; if (empty !== 1'b1) $display("FAIL rel_empty: got %0b want 1", empty); else n_pass++;
      n_total++; if (almost_empty !== 1'b1) $display("FAIL rel_ae: got %0b want 1", almost_empty); else n_pass++;
      n_total++; if (rpt !== 5'd0) $display("FAIL rel_rpt: got %0h want 0", rpt); else n_pass++;
      n_total++; if (rd_count !== 5'd0) $display("FAIL rel_count: got %0d want 0", rd_count); else n_pass++;
   endtask

   task automatic test_write_latency();
      wpt   = g(3);
      rd_en = 1'b0;
      @(posedge RCLK); #1;
      n_total++; if (empty !== 1'b1) $display("FAIL lat_e1_empty: got %0b want 1", empty); else n_pass++;
      @(posedge RCLK); #1;
      n_total++; if (empty !== 1'b1) $display("FAIL lat_e2_empty: got %0b want 1", empty); else n_pass++;
      @(posedge RCLK); #1;
      n_total++; if (empty !== 1'b0) $display("FAIL lat_e3_empty: got %0b want 0", empty); else n_pass++;
      n_total++; if (rd_count !== 5'd3) $display("FAIL lat_e3_count: got %0d want 3", rd_count); else n_pass++;
      n_total++; if (almost_empty !== 1'b0) $display("FAIL lat_e3_ae: got %0b want 0", almost_empty); else n_pass++;
      @(negedge RCLK);
   endtask

   task automatic test_drain();
      logic       exp_mren[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [4:0] exp_rpt[5]   = '{5'b00001, 5'b00011, 5'b00010, 5'b00010, 5'b00010};
      logic       exp_uf[5]    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic       exp_empty[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [3:0] want;
      for (int k = 0; k < 3; k++) sb.push_back(4'(k));
      rd_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_total++; if (mem_ren !== exp_mren[i]) $display("FAIL drain_mren[%0d]: got %0b want %0b", i, mem_ren, exp_mren[i]); else n_pass++;
         if (mem_ren === 1'b1) begin
            want = (sb.size() > 0) ? sb.pop_front() : 4'hx;
            n_total++; if (raddr !== want) $display("FAIL drain_raddr[%0d]: got %0d want %0d", i, raddr, want); else n_pass++;
         end
         @(posedge RCLK); #1;
         n_total++; if (rpt !== exp_rpt[i]) $display("FAIL drain_rpt[%0d]: got %b want %b", i, rpt, exp_rpt[i]); else n_pass++;
         n_total++; if (underflow !== exp_uf[i]) $display("FAIL drain_uf[%0d]: got %0b want %0b", i, underflow, exp_uf[i]); else n_pass++;
         n_total++; if (empty !== exp_empty[i]) $display("FAIL drain_empty[%0d]: got %0b want %0b", i, empty, exp_empty[i]); else n_pass++;
         @(negedge RCLK);
      end
      rd_en = 1'b0;
      n_total++; if (sb.size() != 0) $display("FAIL drain_sb_left: got %0d want 0", sb.size()); else n_pass++;
      n_total++; if (raddr !== 4'd3) $display("FAIL drain_rbin: got %0d want 3", raddr); else n_pass++;
      n_total++; if (rd_count !== 5'd0) $display("FAIL drain_count: got %0d want 0", rd_count); else n_pass++;
      @(posedge RCLK); #1;
      n_total++; if (underflow !== 1'b0) $display("FAIL drain_uf_end: got %0b want 0", underflow); else n_pass++;
      @(negedge RCLK);
   endtask

   task automatic test_full_level();
      int acc;
      do_reset();
      wpt = g(16);
      repeat (3) @(negedge RCLK);
      n_total++; if (rd_count !== 5'd16) $display("FAIL full_count: got %0d want 16", rd_count); else n_pass++;
      n_total++; if (empty !== 1'b0) $display("FAIL full_empty: got %0b want 0", empty); else n_pass++;
      n_total++; if (almost_empty !== 1'b0) $display("FAIL full_ae: got %0b want 0", almost_empty); else n_pass++;
      acc   = 0;
      rd_en = 1'b1;
      repeat (16) begin
         #1;
         if (mem_ren === 1'b1) acc++;
         @(negedge RCLK);
      end
      rd_en = 1'b0;
      n_total++; if (acc != 16) $display("FAIL full_accepts: got %0d want 16", acc); else n_pass++;
      n_total++; if (empty !== 1'b1) $display("FAIL full_drained_empty: got %0b want 1", empty); else n_pass++;
      n_total++; if (rd_count !== 5'd0) $display("FAIL full_drained_count: got %0d want 0", rd_count); else n_pass++;
      n_total++; if (rpt !== 5'b11000) $display("FAIL full_drained_rpt: got %b want 11000", rpt); else n_pass++;
      n_total++; if (raddr !== 4'd0) $display("FAIL full_drained_raddr: got %0d want 0", raddr); else n_pass++;
   endtask

   task automatic test_wrap();
      int w;
      int acc;
      int cyc;
      logic [4:0] prev;
      logic [3:0] want;
      do_reset();
      rd_en = 1'b1;
      w     = 0;
      acc   = 0;
      cyc   = 0;
      prev  = rpt;
      while ((w < 40 || sb.size() > 0) && cyc < 200) begin
         #1;
         if (rpt !== prev) begin
            n_total++; if ($countones(rpt ^ prev) != 1) $display("FAIL wrap_hamming: got %b from %b want one-bit step", rpt, prev); else n_pass++;
            prev = rpt;
         end
         if (mem_ren === 1'b1) begin
            acc++;
            want = (sb.size() > 0) ? sb.pop_front() : 4'hx;
            n_total++; if (raddr !== want) $display("FAIL wrap_raddr[%0d]: got %0d want %0d", acc, raddr, want); else n_pass++;
         end
         if (w < 40) begin
            w++;
            wpt = g(w);
            sb.push_back(4'(w - 1));
         end
         @(negedge RCLK);
         cyc++;
      end
      n_total++; if (cyc >= 200) $display("FAIL wrap_timeout: got %0d cycles want <200", cyc); else n_pass++;
      repeat (4) @(negedge RCLK);
      n_total++; if (acc != 40) $display("FAIL wrap_accepts: got %0d want 40", acc); else n_pass++;
      n_total++; if (rpt !== g(40)) $display("FAIL wrap_rpt: got %b want %b", rpt, g(40)); else n_pass++;
      n_total++; if (empty !== 1'b1) $display("FAIL wrap_empty: got %0b want 1", empty); else n_pass++;
      n_total++; if (rd_count !== 5'd0) $display("FAIL wrap_count: got %0d want 0", rd_count); else n_pass++;
      n_total++; if (underflow !== 1'b1) $display("FAIL wrap_uf_held: got %0b want 1", underflow); else n_pass++;
      rd_en = 1'b0;
      @(negedge RCLK);
   endtask

   task automatic test_reset_mid();
      do_reset();
      wpt = g(10);
      repeat (3) @(negedge RCLK);
      n_total++; if (rd_count !== 5'd10) $display("FAIL mid_count_pre: got %0d want 10", rd_count); else n_pass++;
      rd_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_total++; if (mem_ren !== 1'b1 || raddr !== 4'(i)) $display("FAIL mid_read[%0d]: got ren=%0b addr=%0d want ren=1 addr=%0d", i, mem_ren, raddr, i); else n_pass++;
         @(negedge RCLK);
      end
      #2;
      RRSTn = 1'b0;
      #1;
      n_total++; if (rpt !== 5'd0) $display("FAIL mid_rpt: got %b want 0", rpt); else n_pass++;
      n_total++; if (raddr !== 4'd0) $display("FAIL mid_raddr: got %0d want 0", raddr); else n_pass++;
      n_total++; if (empty !== 1'b1) $display("FAIL mid_empty: got %0b want 1", empty); else n_pass++;
      n_total++; if (rd_count !== 5'd0) $display("FAIL mid_count: got %0d want 0", rd_count); else n_pass++;
      n_total++; if (almost_empty !== 1'b1) $display("FAIL mid_ae: got %0b want 1", almost_empty); else n_pass++;
      n_total++; if (mem_ren !== 1'b0) $display("FAIL mid_mren: got %0b want 0", mem_ren); else n_pass++;
      rd_en = 1'b0;
      @(negedge RCLK);
      RRSTn = 1'b1;
      @(posedge RCLK); #1;
      n_total++; if (empty !== 1'b1) $display("FAIL mid_resync_e1: got %0b want 1", empty); else n_pass++;
      @(posedge RCLK); #1;
      n_total++; if (empty !== 1'b1) $display("FAIL mid_resync_e2: got %0b want 1", empty); else n_pass++;
      @(posedge RCLK); #1;
      n_total++; if (empty !== 1'b0) $display("FAIL mid_resync_e3: got %0b want 0", empty); else n_pass++;
      n_total++; if (rd_count !== 5'd10) $display("FAIL mid_resync_count: got %0d want 10", rd_count); else n_pass++;
      n_total++; if (underflow !== 1'b0) $display("FAIL mid_resync_uf: got %0b want 0", underflow); else n_pass++;
      @(negedge RCLK);
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      RRSTn   = 1'b0;
      rd_en   = 1'b0;
      wpt     = '0;
      test_reset();
      test_write_latency();
      test_drain();
      test_full_level();
      test_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not complete within 100000 time units");
      $fatal(1);
   end

endmodule
